io_uart_bridge: RTL and testbench
=================================

IO_UART_BRIDGE -- requirements
Module: io_uart_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, sets clock cycles per serial bit; it SHALL be an even value of at least 4.
REQ-002 clk  in  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 wr_stb  in  1  one-cycle CPU write strobe for a transmit byte.
REQ-005 wr_data  in  8  transmit byte, sampled when wr_stb=1.
REQ-006 rd_stb  in  1  one-cycle CPU read-acknowledge strobe for the receive byte.
REQ-007 rd_data  out  8  last received byte; driven to the CPU input-device port.
REQ-008 status  out  8  {4'b0, frame_err, overrun, rx_valid, tx_ready}.
REQ-009 txd  out  1  serial output, idle high; SHALL be registered.
REQ-010 rxd  in  1  serial input, asynchronous to clk.

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held CLKS_PER_BIT cycles.
REQ-012 TX path SHALL use a 1-byte holding register plus a shift register; tx_ready=1 while the holding register is empty.
REQ-013 wr_stb with tx_ready=1 SHALL load the holding register; wr_stb with tx_ready=0 SHALL be ignored, with no state change.
REQ-014 TX FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on the edge after the holding register fills, moving holding->shift and setting tx_ready=1 on that same edge.
REQ-015 Latency: wr_stb sampled at edge N in IDLE -> txd=0 from edge N+1.
REQ-016 On STOP completion: if the holding register is full -> START directly, with no idle gap; otherwise -> IDLE with txd=1.
REQ-017 rxd SHALL pass through a 2-flop synchronizer reset to 1; all RX decisions SHALL use the synchronized value.
REQ-018 RX FSM states SHALL be IDLE, START, DATA, STOP, BREAK; IDLE->START on synchronized rxd=0.
REQ-019 START: at CLKS_PER_BIT/2 cycles, rxd=0 -> DATA; rxd=1 -> IDLE (glitch reject, no flags).
REQ-020 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from mid-start; STOP SHALL sample one further CLKS_PER_BIT later.
REQ-021 Stop bit=1 -> rd_data updated, rx_valid=1; if rx_valid was already 1 -> overrun=1 and rd_data is overwritten with the new byte.
REQ-022 Stop bit=0 -> frame_err=1, rd_data and rx_valid unchanged, go to BREAK; BREAK -> IDLE when rxd=1.
REQ-023 rd_stb SHALL clear rx_valid, overrun and frame_err on the next edge.
REQ-024 rd_stb in the same cycle as byte completion: rx_valid stays 1, overrun not set, rd_data = new byte; any flag set in the same cycle as its clear SHALL end set.
REQ-025 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-026 rst=1 SHALL immediately force txd=1, rd_data=8'h00, status=8'h01, both FSMs to IDLE, holding register empty, and synchronizer flops to 1.
REQ-027 rst asserted mid-frame SHALL abort the frame without completing it; after release the first activity SHALL begin from IDLE.

Verification (CLKS_PER_BIT=4)
REQ-028 wr_stb with 8'hA5 in IDLE -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; txd low from the next edge; tx_ready back to 1 one edge after the strobe.
REQ-029 Writes 8'h00 then 8'hFF (second write while busy), then a third write while the holding register is full -> 20 contiguous bit-times carrying 00 and FF; third byte dropped; txd=1 afterwards.
REQ-030 RX frame for 8'h3C -> rd_data=8'h3C, status=8'h03; rd_stb -> status=8'h01.
REQ-031 Two RX frames 8'h11, 8'h22 without rd_stb -> rd_data=8'h22, status=8'h07.
REQ-032 RX frame with stop bit=0 -> status=8'h09 with rd_data unchanged; a 1-cycle low glitch on rxd -> no change in status or rd_data.
REQ-033 rst pulsed mid-TX of 8'hF0 -> txd=1 within the same cycle, status=8'h01; a fresh write after release transmits correctly.

Source files
------------

// File: rtl/io_uart_bridge.sv
`timescale 1ns/1ps
// io_uart_bridge
//   Byte-wide CPU-to-serial bridge: one UART transmitter (holding register
//   plus shift register) and one UART receiver with status flags. Frames are
//   8N1 (start 0, eight data bits LSB first, stop 1); every bit lasts
//   CLKS_PER_BIT clocks. CLKS_PER_BIT must be even and at least 4.
//
//   Ports
//     clk      system clock, all state changes on its rising edge
//     rst      asynchronous active-high reset
//     wr_stb   one-cycle write strobe, loads wr_data when tx_ready=1
//     wr_data  byte to transmit
//     rd_stb   one-cycle read acknowledge, clears rx_valid/overrun/frame_err
//     rd_data  last byte received
//     status   {4'b0, frame_err, overrun, rx_valid, tx_ready}
//     txd      registered serial output, idle high
//     rxd      serial input, asynchronous to clk
module io_uart_bridge #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  input  logic       rd_stb,
  output logic [7:0] rd_data,
  output logic [7:0] status,
  output logic       txd,
  input  logic       rxd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // ---------------- transmit path ----------------
  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_txd, w_txd_nxt;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             w_tx_take;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_txd_nxt      = r_txd;
    w_tx_take      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_hold_full) begin
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = r_hold;
          w_txd_nxt      = 1'b0;
          w_tx_take      = 1'b1;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_txd_nxt      = r_tx_shift[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
            w_txd_nxt      = 1'b1;
          end else begin
            // txd already shows bit 0 of the shifter; present the next one
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_txd_nxt      = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_END) begin
          w_tx_cnt_nxt = '0;
          if (r_hold_full) begin
            // back-to-back frame: no idle gap between stop and next start
            w_tx_state_nxt = TX_START;
            w_tx_shift_nxt = r_hold;
            w_txd_nxt      = 1'b0;
            w_tx_take      = 1'b1;
          end else begin
            w_tx_state_nxt = TX_IDLE;
            w_txd_nxt      = 1'b1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_txd_nxt      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_txd       <= 1'b1;
      r_hold_full <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_tx_bit    <= w_tx_bit_nxt;
      r_txd       <= w_txd_nxt;
      // a write is only accepted while empty, so load and take never collide
      r_hold_full <= (r_hold_full & ~w_tx_take) | (wr_stb & ~r_hold_full);
    end
  end

  // byte storage carries no reset: it is only read after being loaded
  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift_nxt;
    if (wr_stb && !r_hold_full) r_hold <= wr_data;
  end

  // ---------------- receive path ----------------
  logic             r_rx_s1, r_rx_s2;
  logic             w_rxd;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic             w_rx_done, w_rx_ferr;
  logic             r_rx_valid, r_overrun, r_frame_err;
  logic [7:0]       r_rd_data;

  assign w_rxd = r_rx_s2;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_done      = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rxd) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // re-check at mid start bit; a line already back high was a glitch
        if (r_rx_cnt == HALF_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = w_rxd ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {w_rxd, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_END) begin
          w_rx_cnt_nxt = '0;
          if (w_rxd) begin
            w_rx_done      = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            // hold off until the line returns high before hunting again
            w_rx_ferr      = 1'b1;
            w_rx_state_nxt = RX_BREAK;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RX_BREAK: begin
        if (w_rxd) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_data   <= 8'h00;
    end else begin
      r_rx_s1     <= rxd;
      r_rx_s2     <= r_rx_s1;
      r_rx_state  <= w_rx_state_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_rx_bit    <= w_rx_bit_nxt;
      // a flag being set wins over a same-cycle clear; a read in the
      // completion cycle counts as consuming the old byte, so no overrun
      r_rx_valid  <= w_rx_done | (r_rx_valid & ~rd_stb);
      r_overrun   <= (w_rx_done & r_rx_valid & ~rd_stb) | (r_overrun & ~rd_stb);
      r_frame_err <= w_rx_ferr | (r_frame_err & ~rd_stb);
      if (w_rx_done) r_rd_data <= r_rx_shift;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nxt;
  end

  assign txd     = r_txd;
  assign rd_data = r_rd_data;
  assign status  = {4'b0000, r_frame_err, r_overrun, r_rx_valid, ~r_hold_full};

endmodule

// File: tb/tb_io_uart_bridge.sv
`timescale 1ns/1ps
// tb_io_uart_bridge
//   Directed bench for io_uart_bridge at CLKS_PER_BIT=4: table-driven TX
//   frames and RX frame/strobe records, plus hand sequences for back-to-back
//   transmit, mid-frame reset and concurrent TX/RX.
module tb_io_uart_bridge;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst, wr_stb, rd_stb, rxd, txd;
  logic [7:0] wr_data, rd_data, status;

  int n_chk  = 0;
  int n_fail = 0;

  io_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_data(rd_data), .status(status),
    .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // seq[i] = expected txd during bit-time i
  } tx_vec_t;

  // kind: 0 = frame, 1 = rd_stb pulse, 2 = one-cycle low glitch
  typedef struct {
    int         kind;
    logic [7:0] byte_v;
    logic       stop;
    logic       rd_at_done;
    logic [7:0] exp_rd;
    logic [7:0] exp_st;
  } rx_vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_frame(input logic [7:0] data, input logic [9:0] seq);
    wr_data = data;
    wr_stb  = 1'b1;
    tick;
    chk($sformatf("tx %h ready after strobe", data), status[0], 1'b0);
    chk($sformatf("tx %h txd after strobe", data), txd, 1'b1);
    wr_stb = 1'b0;
    tick;
    chk($sformatf("tx %h ready after move", data), status[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        chk($sformatf("tx %h bit %0d cyc %0d", data, i, j), txd, seq[i]);
        tick;
      end
    end
    chk($sformatf("tx %h idle after frame", data), txd, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input logic rd_at_done);
    rxd = 1'b0;
    repeat (CPB) tick;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick;
    end
    rxd = stop;
    repeat (CPB) tick;
    // the receiver decides on the stop bit at the next edge
    rxd    = 1'b1;
    rd_stb = rd_at_done;
    tick;
    rd_stb = 1'b0;
  endtask

  tx_vec_t    txv[3];
  rx_vec_t    rxv[12];
  logic [19:0] seq20;

  initial begin
    txv[0] = '{8'hA5, 10'h34A};
    txv[1] = '{8'h3C, 10'h278};
    txv[2] = '{8'h81, 10'h302};

    rxv[0]  = '{0, 8'h3C, 1'b1, 1'b0, 8'h3C, 8'h03};
    rxv[1]  = '{1, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h01};
    rxv[2]  = '{0, 8'h11, 1'b1, 1'b0, 8'h11, 8'h03};
    rxv[3]  = '{0, 8'h22, 1'b1, 1'b0, 8'h22, 8'h07};
    rxv[4]  = '{1, 8'h00, 1'b1, 1'b0, 8'h22, 8'h01};
    rxv[5]  = '{0, 8'h55, 1'b0, 1'b0, 8'h22, 8'h09};
    rxv[6]  = '{1, 8'h00, 1'b1, 1'b0, 8'h22, 8'h01};
    rxv[7]  = '{2, 8'h00, 1'b1, 1'b0, 8'h22, 8'h01};
    rxv[8]  = '{0, 8'hA5, 1'b1, 1'b0, 8'hA5, 8'h03};
    rxv[9]  = '{0, 8'h66, 1'b1, 1'b1, 8'h66, 8'h03};
    rxv[10] = '{0, 8'h77, 1'b0, 1'b1, 8'h66, 8'h09};
    rxv[11] = '{1, 8'h00, 1'b1, 1'b0, 8'h66, 8'h01};

    rst = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; wr_data = 8'h00; rxd = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset txd", txd, 1'b1);
    chk("reset status", status, 8'h01);
    chk("reset rd_data", rd_data, 8'h00);
    repeat (3) tick;
    rst = 1'b0;
    repeat (4) tick;
    chk("post-reset status", status, 8'h01);
    chk("post-reset txd", txd, 1'b1);

    // single TX frames
    for (int v = 0; v < 3; v++) begin
      tx_frame(txv[v].data, txv[v].seq);
      repeat (3) tick;
    end

    // back-to-back: 00, FF while busy, 5A while holding register full
    seq20   = {10'h3FE, 10'h200};
    wr_data = 8'h00;
    wr_stb  = 1'b1;
    tick;
    wr_stb = 1'b0;
    tick;
    for (int k = 0; k < 80; k++) begin
      chk($sformatf("b2b bit %0d cyc %0d", k / 4, k % 4), txd, seq20[k / 4]);
      if (k == 0)      begin wr_stb = 1'b1; wr_data = 8'hFF; end
      else if (k == 1) begin wr_stb = 1'b1; wr_data = 8'h5A; end
      else             wr_stb = 1'b0;
      tick;
      if (k < 2) chk($sformatf("b2b ready k=%0d", k), status[0], 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("b2b idle %0d", k), txd, 1'b1);
      chk($sformatf("b2b ready idle %0d", k), status[0], 1'b1);
      repeat (4) tick;
    end

    // RX records
    for (int v = 0; v < 12; v++) begin
      case (rxv[v].kind)
        0: send_rx(rxv[v].byte_v, rxv[v].stop, rxv[v].rd_at_done);
        1: begin rd_stb = 1'b1; tick; rd_stb = 1'b0; end
        default: begin rxd = 1'b0; tick; rxd = 1'b1; repeat (8) tick; end
      endcase
      chk($sformatf("rx rec %0d rd_data", v), rd_data, rxv[v].exp_rd);
      chk($sformatf("rx rec %0d status", v), status, rxv[v].exp_st);
      repeat (4) tick;
    end

    // reset in the middle of a TX frame of F0 and an RX frame
    rxd     = 1'b0;
    wr_data = 8'hF0;
    wr_stb  = 1'b1;
    tick;
    wr_stb = 1'b0;
    repeat (9) tick;
    chk("mid-frame txd low", txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid reset txd", txd, 1'b1);
    chk("mid reset status", status, 8'h01);
    chk("mid reset rd_data", rd_data, 8'h00);
    rxd = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    repeat (4) tick;
    chk("after reset txd", txd, 1'b1);
    chk("after reset status", status, 8'h01);
    tx_frame(8'h3C, 10'h278);
    repeat (2) tick;
    send_rx(8'hC3, 1'b1, 1'b0);
    chk("after reset rx rd_data", rd_data, 8'hC3);
    chk("after reset rx status", status, 8'h03);
    rd_stb = 1'b1;
    tick;
    rd_stb = 1'b0;
    chk("rd clear status", status, 8'h01);

    // TX and RX running together
    fork
      tx_frame(8'h5A, 10'h2B4);
      send_rx(8'h96, 1'b1, 1'b0);
    join
    repeat (2) tick;
    chk("concurrent rd_data", rd_data, 8'h96);
    chk("concurrent status", status, 8'h03);
    chk("concurrent txd idle", txd, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
